// File: rtl/fifo_axis_upsizer_if.sv
// Bundles the FIFO read port and the AXI-Stream master port of the upsizer.
// master = the upsizer's view, slave = the FIFO/sink environment's view.
interface fifo_axis_upsizer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  logic [IN_WIDTH:0]          fifo_dout;
  logic                       fifo_empty;
  logic                       fifo_rd_en;
  logic [IN_WIDTH*RATIO-1:0]  m_axis_tdata;
  logic [RATIO-1:0]           m_axis_tkeep;
  logic                       m_axis_tlast;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;

  modport master (
    input  fifo_dout, fifo_empty, m_axis_tready,
    output fifo_rd_en, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output fifo_dout, fifo_empty, m_axis_tready,
    input  fifo_rd_en, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/fifo_axis_upsizer.sv
// Pops tagged narrow words from a first-word-fall-through FIFO and packs RATIO
// of them into one wide AXI-Stream beat. A last tag closes the beat early,
// giving a partial beat whose tkeep is contiguous from lane 0.
module fifo_axis_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_axis_upsizer_if.master bus
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LANE_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(RATIO - 1);

  // Accumulator state
  logic [OUT_WIDTH-1:0]  r_acc_data;
  logic [RATIO-1:0]      r_acc_keep;
  logic [LANE_BITS-1:0]  r_lane_idx;

  // Output stage
  logic [OUT_WIDTH-1:0]  r_tdata;
  logic [RATIO-1:0]      r_tkeep;
  logic                  r_tlast;
  logic                  r_tvalid;

  logic [IN_WIDTH-1:0]   w_word;
  logic                  w_tag;
  logic                  w_completes;
  logic                  w_out_free;
  logic                  w_pop;
  logic [RATIO-1:0]      w_lane_onehot;
  logic [RATIO-1:0]      w_merged_keep;
  logic [OUT_WIDTH-1:0]  w_merged_data;

  assign w_word        = bus.fifo_dout[IN_WIDTH-1:0];
  assign w_tag         = bus.fifo_dout[IN_WIDTH];
  assign w_completes   = (r_lane_idx == LAST_LANE) || w_tag;
  assign w_out_free    = !r_tvalid || bus.m_axis_tready;
  // A completing pop needs room in the output stage; any other pop only
  // fills the accumulator, so it may proceed while the sink stalls.
  assign w_pop         = !bus.fifo_empty && !rst && (!w_completes || w_out_free);
  assign w_lane_onehot = {{(RATIO-1){1'b0}}, 1'b1} << r_lane_idx;
  assign w_merged_keep = r_acc_keep | w_lane_onehot;

  // Accumulator contents with the head word placed in the current lane;
  // lanes above the current one are forced to zero.
  always_comb begin
    w_merged_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (LANE_BITS'(k) < r_lane_idx)
        w_merged_data[k*IN_WIDTH +: IN_WIDTH] = r_acc_data[k*IN_WIDTH +: IN_WIDTH];
      else if (LANE_BITS'(k) == r_lane_idx)
        w_merged_data[k*IN_WIDTH +: IN_WIDTH] = w_word;
    end
  end

  // Accumulator: gather words lane by lane, clear when a beat is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_data <= '0;
      r_acc_keep <= '0;
      r_lane_idx <= '0;
    end else if (w_pop) begin
      if (w_completes) begin
        r_acc_data <= '0;
        r_acc_keep <= '0;
        r_lane_idx <= '0;
      end else begin
        r_acc_data <= w_merged_data;
        r_acc_keep <= w_merged_keep;
        r_lane_idx <= r_lane_idx + 1'b1;
      end
    end
  end

  // Output register: load on a completing pop (also in the accept cycle,
  // so back-to-back beats have no bubble), hold while stalled, drop valid
  // after a handshake with nothing new to send.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_pop && w_completes) begin
      r_tdata  <= w_merged_data;
      r_tkeep  <= w_merged_keep;
      r_tlast  <= w_tag;
      r_tvalid <= 1'b1;
    end else if (r_tvalid && bus.m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign bus.fifo_rd_en    = w_pop;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tkeep  = r_tkeep;
  assign bus.m_axis_tlast  = r_tlast;
  assign bus.m_axis_tvalid = r_tvalid;

endmodule

// File: doc/fifo_axis_upsizer.md
Name: fifo_axis_upsizer

Overview:
Downstream consumer of the team's first-word-fall-through LUTRAM FIFO. It pops narrow words, each tagged with a last bit, from the FIFO read port. It packs RATIO words into one wide AXI-Stream beat with per-lane keep and last, behind a registered output stage. It sustains one FIFO pop per cycle when the sink is ready.

Parameters:
IN_WIDTH, 8, data bits per FIFO word, excluding the last tag.
RATIO, 4, input words per output beat; power of 2, >= 2.
Derived: OUT_WIDTH = IN_WIDTH*RATIO; LANE_BITS = log2(RATIO).

Ports:
clk  in  1  clock; all interfaces synchronous to it
rst  in  1  reset, synchronous, active-high
fifo_dout  in  IN_WIDTH+1  FIFO head word; bit IN_WIDTH = last tag, bits IN_WIDTH-1:0 = data
fifo_empty  in  1  FIFO empty; fifo_dout valid only when low
fifo_rd_en  out  1  pop request, combinational
m_axis_tdata  out  OUT_WIDTH  packed beat; lane k = bits (k+1)*IN_WIDTH-1 : k*IN_WIDTH
m_axis_tkeep  out  RATIO  one bit per lane; bit k set = lane k valid
m_axis_tlast  out  1  beat ends a packet
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink accepts beat

Behaviour:
- FIFO side (FWFT)
  - Head word is present whenever fifo_empty=0.
  - Asserting fifo_rd_en consumes the word in that same cycle.
  - fifo_rd_en is never asserted while fifo_empty=1 or rst=1.
- Accumulator
  - Register acc_data[OUT_WIDTH], acc_keep[RATIO], lane counter lane_idx[LANE_BITS].
  - A popped word is written into lane lane_idx; acc_keep[lane_idx] is set.
  - Pop "completes" the beat when lane_idx==RATIO-1 or the word's last tag =1.
- Output stage
  - Registers tdata, tkeep, tlast, tvalid.
  - out_free = !m_axis_tvalid || m_axis_tready.
- Pop rule
  - fifo_rd_en = !fifo_empty && !rst && (!completes || out_free).
  - A non-completing pop is always allowed, so the accumulator fills while the output stalls.
- On a completing pop (cycle t), at t+1:
  - tdata = acc_data with the current word merged in; lanes above lane_idx are forced to 0.
  - tkeep = acc_keep | (1<<lane_idx); tlast = tag; tvalid=1.
  - Accumulator cleared: acc_data=0, acc_keep=0, lane_idx=0.
- On a non-completing pop: lane_idx increments; output registers unaffected.
- Simultaneous accept and new beat
  - If tvalid && tready and a completing pop occur in the same cycle, the new beat loads with no bubble.
  - If tvalid && tready with no completing pop, tvalid clears at t+1.
- Stall: while tvalid=1 && tready=0, tdata/tkeep/tlast stay stable (AXIS rule). tvalid never deasserts without a handshake.
- Latency: one cycle from the completing pop to tvalid.
- Throughput: sustained 1 pop/cycle, 1 beat per RATIO pops, with full packets and tready=1.
- Partial beats occur only on a last tag. tkeep is always contiguous from lane 0.
- lane_idx wraps RATIO-1 -> 0 only via a beat completion.
- Reset, including mid-packet:
  - tvalid=0, tdata=0, tkeep=0, tlast=0; acc_data=0, acc_keep=0, lane_idx=0.
  - A partially packed beat is discarded. The next popped word lands in lane 0.
  - FIFO contents are not touched by this block.

Test Plan:
(IN_WIDTH=8, RATIO=4)
1. FIFO holds 0x11,0x22,0x33,0x44 (tag on 0x44), tready=1 -> 4 consecutive pops; one cycle after the 4th pop: tdata=0x44332211, tkeep=0xF, tlast=1, tvalid=1 for exactly 1 cycle.
2. Six-word packet 0x11..0x66 (tag on 0x66), tready=1 -> beat 1: 0x44332211/0xF/last=0; beat 2: 0x00006655/0x3/last=1.
3. Single word 0xA5 with tag -> tdata=0x000000A5, tkeep=0x1, tlast=1.
4. 12 untagged words queued, tready=0 for 10 cycles:
   - beat 1 (0x04030201 for inputs 0x01..0x0C) held stable; 3 further pops, then fifo_rd_en=0;
   - tready=1 -> beats 0x04030201, 0x08070605, 0x0C0B0A09 in order, no loss or duplication.
5. rst pulsed after 2 words of a packet are popped -> tvalid=0 the next cycle; next packet 0xB1..0xB4 (tag) -> tdata=0xB4B3B2B1, tkeep=0xF.
6. fifo_empty held 1 for 20 cycles -> fifo_rd_en=0 and tvalid=0 throughout; a random tready toggle has no effect.
